// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared types and constants for the video pixel feeder slice.
//   PIX_W            : RGB888 pixel width
//   FILL_COLOR_DEF   : colour shown when no valid stream pixel is delivered
//   feeder_state_t   : feeder lock state (SEEK -> ARMED -> RUN)
//   pix_entry_t      : one buffered stream beat, {sof, data}
// -----------------------------------------------------------------------------
package video_pkg;

    localparam int PIX_W = 24;

    localparam logic [PIX_W-1:0] FILL_COLOR_DEF = 24'hFFFFFF;

    // SEEK  : hunting for a start-of-frame beat at the FIFO head
    // ARMED : SOF beat parked at the head, waiting for raster (0,0)
    // RUN   : stream and raster aligned, pixels delivered on request
    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } feeder_state_t;

    typedef struct packed {
        logic             sof;
        logic [PIX_W-1:0] data;
    } pix_entry_t;

    localparam int ENTRY_W = $bits(pix_entry_t);

endpackage

// File: rtl/pix_fifo_fwft.sv
// -----------------------------------------------------------------------------
// pix_fifo_fwft
// Synchronous show-ahead FIFO of pix_entry_t beats. The entry at the read
// pointer is presented on 'head' without a read strobe; 'pop' consumes it.
// A beat written into an empty FIFO only becomes visible once 'level' has
// registered it (no write-to-read bypass).
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset, empties the FIFO
//   push     in   write request (ignored while full)
//   wr_entry in   beat to write
//   pop      in   consume head (ignored while empty)
//   head     out  entry at the read pointer
//   level    out  occupancy, 0..DEPTH
//   full     out  level == DEPTH
//   empty    out  level == 0
// -----------------------------------------------------------------------------
import video_pkg::*;

module pix_fifo_fwft #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  pix_entry_t        wr_entry,
    input  logic              pop,
    output pix_entry_t        head,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);

    pix_entry_t        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == LVL_FULL);
    assign empty   = (level == '0);
    // Full blocks a write even when a pop frees a slot in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by the pointers/level.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH == 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/video_pixel_feeder.sv
// -----------------------------------------------------------------------------
// video_pixel_feeder
// Buffers an RGB888 pixel stream (with start-of-frame flag) for the VGA timing
// controller. A pixel is returned on VideoData in the same cycle VideoReq is
// raised. The stream's SOF is aligned to raster (0,0); on underflow or
// misalignment the fill colour is driven, an error is counted, and the block
// re-locks at the next SOF / (0,0) pair.
//
// Ports:
//   PixelClk   in   pixel clock
//   Rst        in   synchronous active-high reset
//   S_Data     in   stream pixel RGB888
//   S_Sof      in   first pixel of a frame
//   S_Valid    in   stream beat valid
//   S_Ready    out  feeder can accept a beat (low while full or in reset)
//   VideoReq   in   active pixel requested this cycle
//   VideoXPos  in   active X position (valid with VideoReq)
//   VideoYPos  in   active Y position (valid with VideoReq)
//   VideoData  out  pixel for the timing controller, combinational
//   Locked     out  feeder is in RUN
//   ErrCnt     out  saturating underflow / misalignment event count
//   FifoLevel  out  current FIFO occupancy
// -----------------------------------------------------------------------------
import video_pkg::*;

module video_pixel_feeder #(
    parameter int               DEPTH      = 64,
    parameter int               ADDR_W     = 6,
    parameter logic [PIX_W-1:0] FILL_COLOR = FILL_COLOR_DEF
) (
    input  logic              PixelClk,
    input  logic              Rst,
    input  logic [PIX_W-1:0]  S_Data,
    input  logic              S_Sof,
    input  logic              S_Valid,
    output logic              S_Ready,
    input  logic              VideoReq,
    input  logic [11:0]       VideoXPos,
    input  logic [11:0]       VideoYPos,
    output logic [PIX_W-1:0]  VideoData,
    output logic              Locked,
    output logic [15:0]       ErrCnt,
    output logic [ADDR_W:0]   FifoLevel
);

    feeder_state_t    state;
    feeder_state_t    state_nx;
    pix_entry_t       head;
    pix_entry_t       wr_entry;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             err_evt;
    logic             frame_start;
    logic [PIX_W-1:0] pix_out;

    assign frame_start = VideoReq && (VideoXPos == 12'd0) && (VideoYPos == 12'd0);

    // Ready follows the registered level, so a pop cannot open a slot for a
    // push in the same cycle.
    assign S_Ready       = !Rst && !full;
    assign push          = S_Valid && S_Ready;
    assign wr_entry.sof  = S_Sof;
    assign wr_entry.data = S_Data;

    pix_fifo_fwft #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (PixelClk),
        .rst      (Rst),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .head     (head),
        .level    (FifoLevel),
        .full     (full),
        .empty    (empty)
    );

    // Next-state / pop / output-mux decision, evaluated against the current
    // head entry and this cycle's raster request.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        err_evt  = 1'b0;
        pix_out  = FILL_COLOR;
        case (state)
            SEEK: begin
                // Drop non-SOF beats one per cycle; park on the first SOF.
                // Raster requests here are not serviced.
                if (!empty) begin
                    if (head.sof) begin
                        state_nx = ARMED;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (empty) begin
                    state_nx = SEEK;
                end else if (frame_start) begin
                    pop      = 1'b1;
                    pix_out  = head.data;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (VideoReq) begin
                    if (empty) begin
                        // Underflow: stream fell behind the raster.
                        err_evt  = 1'b1;
                        state_nx = SEEK;
                    end else if (head.sof && !frame_start) begin
                        // Stream short: next frame already at the head, keep it.
                        err_evt  = 1'b1;
                        state_nx = ARMED;
                    end else if (frame_start && !head.sof) begin
                        // Stream long: raster wrapped before the stream did.
                        err_evt  = 1'b1;
                        state_nx = SEEK;
                    end else begin
                        pop     = 1'b1;
                        pix_out = head.data;
                    end
                end
            end
            default: begin
                state_nx = SEEK;
            end
        endcase
    end

    assign VideoData = pix_out;

    always_ff @(posedge PixelClk) begin
        if (Rst) begin
            state  <= SEEK;
            Locked <= 1'b0;
            ErrCnt <= 16'd0;
        end else begin
            state  <= state_nx;
            Locked <= (state_nx == RUN);
            if (err_evt && (ErrCnt != 16'hFFFF)) begin
                ErrCnt <= ErrCnt + 16'd1;
            end
        end
    end

endmodule
